// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle controller for register-specified ARM shifts.
// Shifts the latched operand STEP bits per cycle and returns the shifter
// result plus carry-out under a start/busy/done handshake. busy drives the
// pipeline stall while the shift is in progress.
// Optional feature macro: SHIFT_EARLY_EXIT_EN clips the shift amount when it
// is latched, which bounds latency without changing any result.
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  amount,
  input  logic [31:0] operand,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t      state;
  state_t      state_next;

  logic [31:0] val;
  logic        cval;
  logic [7:0]  rem;
  logic [1:0]  typ;

  logic [7:0]  eff_amount;
  logic [7:0]  step_k;
  logic [7:0]  rem_next;
  logic [31:0] shift_val;
  logic        shift_c;
  logic        accept;
  logic        step_en;
  logic        finish;

`ifdef SHIFT_EARLY_EXIT_EN
  // Clip the requested amount to the point where further steps change nothing.
  always_comb begin
    eff_amount = amount;
    case (shift_type)
      T_LSL, T_LSR: begin
        if (amount > 8'd33) begin
          eff_amount = 8'd33;
        end else begin
          eff_amount = amount;
        end
      end
      T_ASR: begin
        if (amount > 8'd32) begin
          eff_amount = 8'd32;
        end else begin
          eff_amount = amount;
        end
      end
      T_ROR: begin
        if ((amount[4:0] == 5'd0) && (amount != 8'd0)) begin
          eff_amount = 8'd32;
        end else begin
          eff_amount = {3'b000, amount[4:0]};
        end
      end
      default: eff_amount = amount;
    endcase
  end
`else
  // Without clipping the full Rs[7:0] value is iterated.
  always_comb begin
    eff_amount = amount;
  end
`endif

  // Bits consumed this cycle and the count left afterwards.
  always_comb begin
    step_k   = (rem > 8'(STEP)) ? 8'(STEP) : rem;
    rem_next = rem - step_k;
  end

  // Apply up to STEP single-bit shifts; carry tracks the last bit moved out.
  always_comb begin
    shift_val = val;
    shift_c   = cval;
    for (int i = 0; i < STEP; i++) begin
      if (8'(i) < step_k) begin
        case (typ)
          T_LSL: begin
            shift_c   = shift_val[31];
            shift_val = {shift_val[30:0], 1'b0};
          end
          T_LSR: begin
            shift_c   = shift_val[0];
            shift_val = {1'b0, shift_val[31:1]};
          end
          T_ASR: begin
            shift_c   = shift_val[0];
            shift_val = {shift_val[31], shift_val[31:1]};
          end
          T_ROR: begin
            shift_val = {shift_val[0], shift_val[31:1]};
            shift_c   = shift_val[31];
          end
          default: begin
            shift_val = shift_val;
            shift_c   = shift_c;
          end
        endcase
      end else begin
        shift_val = shift_val;
        shift_c   = shift_c;
      end
    end
  end

  // Next-state decode; flush outranks start in every state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !flush) begin
          accept = 1'b1;
          if (eff_amount == 8'd0) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step_en = 1'b1;
          if (rem_next == 8'd0) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == SHIFT);
      done  <= (state_next == DONE);
    end
  end

  // Working registers and the held result/carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val       <= 32'd0;
      cval      <= 1'b0;
      rem       <= 8'd0;
      typ       <= 2'b00;
      result    <= 32'd0;
      carry_out <= 1'b0;
    end else begin
      if (accept) begin
        val  <= operand;
        cval <= carry_in;
        rem  <= eff_amount;
        typ  <= shift_type;
        if (eff_amount == 8'd0) begin
          result    <= operand;
          carry_out <= carry_in;
        end
      end else if (step_en) begin
        val  <= shift_val;
        cval <= shift_c;
        rem  <= rem_next;
        if (finish) begin
          result    <= shift_val;
          carry_out <= shift_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, hand-written
// multi-cycle sequences and randomized operations against a reference model.
module tb_shift_sequencer;

  localparam int STEP = 4;
`ifdef SHIFT_EARLY_EXIT_EN
  localparam int LAT200 = 10;
`else
  localparam int LAT200 = 51;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  shift_type;
  logic [7:0]  amount;
  logic [31:0] operand;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  a;
    logic [31:0] op;
    logic        cin;
    logic [31:0] res;
    logic        c;
  } vec_t;

  vec_t vecs[10];

  shift_sequencer #(.STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .shift_type (shift_type),
    .amount     (amount),
    .operand    (operand),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference ARM shifter computed from the architectural definition.
  function automatic void ref_shift(input logic [1:0] t, input int amt, input logic [31:0] op,
                                    input logic cin, output logic [31:0] r, output logic c);
    logic [63:0]        w;
    logic signed [63:0] s;
    int                 a;
    r = op;
    c = cin;
    if (amt != 0) begin
      case (t)
        2'b00: begin
          if (amt < 32) begin
            w = {32'd0, op} << amt; r = w[31:0]; c = w[32];
          end else if (amt == 32) begin
            r = 32'd0; c = op[0];
          end else begin
            r = 32'd0; c = 1'b0;
          end
        end
        2'b01: begin
          if (amt < 32) begin
            w = {op, 32'd0} >> amt; r = w[63:32]; c = w[31];
          end else if (amt == 32) begin
            r = 32'd0; c = op[31];
          end else begin
            r = 32'd0; c = 1'b0;
          end
        end
        2'b10: begin
          if (amt < 32) begin
            s = {op, 32'd0}; s = s >>> amt; r = s[63:32]; c = s[31];
          end else begin
            r = {32{op[31]}}; c = op[31];
          end
        end
        default: begin
          a = amt % 32;
          if (a == 0) begin
            r = op; c = op[31];
          end else begin
            w = {op, op} >> a; r = w[31:0]; c = r[31];
          end
        end
      endcase
    end
  endfunction

  // Cycle (counted from the start edge) in which done is expected.
  function automatic int exp_cycles(input logic [1:0] t, input int amt);
    int e;
    e = amt;
`ifdef SHIFT_EARLY_EXIT_EN
    if (t == 2'b00 || t == 2'b01) e = (amt > 33) ? 33 : amt;
    else if (t == 2'b10)          e = (amt > 32) ? 32 : amt;
    else                          e = ((amt % 32) == 0 && amt != 0) ? 32 : (amt % 32);
`endif
    return (e + STEP - 1) / STEP + 1;
  endfunction

  // Issue one operation and wait (bounded) for done; returns in the done cycle.
  task automatic run_op(input logic [1:0] t, input logic [7:0] a, input logic [31:0] op,
                        input logic cin, output int cyc, output int nbusy, output logic ok);
    @(posedge clk); #1;
    shift_type = t; amount = a; operand = op; carry_in = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand = ~op; amount = a ^ 8'h5A; shift_type = ~t; carry_in = ~cin;
    cyc = 1;
    nbusy = 0;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic op_check(input string name, input logic [1:0] t, input logic [7:0] a,
                          input logic [31:0] op, input logic cin,
                          input logic [31:0] er, input logic ec);
    int   cyc;
    int   nb;
    logic ok;
    run_op(t, a, op, cin, cyc, nb, ok);
    chk({name, " timeout"}, 32'(ok), 32'd1);
    chk({name, " result"}, result, er);
    chk({name, " carry"}, 32'(carry_out), 32'(ec));
    chk({name, " cycles"}, 32'(cyc), 32'(exp_cycles(t, int'(a))));
    chk({name, " busy_cycles"}, 32'(nb), 32'(exp_cycles(t, int'(a)) - 1));
    chk({name, " busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          cyc;
    int          nb;
    logic        ok;
    logic        seen;
    logic [1:0]  rt;
    logic [7:0]  ra;
    logic [31:0] rop;
    logic        rcin;
    logic [31:0] er;
    logic        ec;

    checks = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    shift_type = 2'b00; amount = 8'd0; operand = 32'd0; carry_in = 1'b0;

    vecs[0] = '{2'b00, 8'd4,   32'h00000001, 1'b0, 32'h00000010, 1'b0};
    vecs[1] = '{2'b01, 8'd1,   32'h80000001, 1'b0, 32'h40000000, 1'b1};
    vecs[2] = '{2'b11, 8'd4,   32'h000000F1, 1'b1, 32'h1000000F, 1'b0};
    vecs[3] = '{2'b00, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1};
    vecs[4] = '{2'b00, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{2'b00, 8'd33,  32'h00000001, 1'b1, 32'h00000000, 1'b0};
    vecs[6] = '{2'b10, 8'd40,  32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{2'b11, 8'd64,  32'h80000001, 1'b0, 32'h80000001, 1'b1};
    vecs[8] = '{2'b01, 8'd200, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0};
    vecs[9] = '{2'b10, 8'd4,   32'h7FFFFFF0, 1'b1, 32'h07FFFFFF, 1'b0};

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset carry", 32'(carry_out), 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op_check($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].op, vecs[i].cin,
               vecs[i].res, vecs[i].c);
    end

    run_op(2'b01, 8'd200, 32'hFFFFFFFF, 1'b1, cyc, nb, ok);
    chk("lsr200 latency", 32'(cyc), 32'(LAT200));

    // Start ignored while busy: LSL 1 by 8 must finish in cycle 3 with 0x100.
    @(posedge clk); #1;
    shift_type = 2'b00; amount = 8'd8; operand = 32'h1; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    shift_type = 2'b11; amount = 8'd0; operand = 32'hFFFF0000; carry_in = 1'b1;
    chk("ign busy c1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign busy c2", 32'(busy), 32'd1);
    chk("ign done c2", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("ign done c3", 32'(done), 32'd1);
    chk("ign result", result, 32'h00000100);
    chk("ign carry", 32'(carry_out), 32'd0);

    // Flush in the second SHIFT cycle of LSL by 16.
    op_check("base", 2'b00, 8'd4, 32'h1, 1'b0, 32'h10, 1'b0);
    @(posedge clk); #1;
    shift_type = 2'b00; amount = 8'd16; operand = 32'hFF; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    amount = 8'd0; operand = 32'hDEADBEEF;
    chk("flush busy c1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    chk("flush busy c2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush idle busy", 32'(busy), 32'd0);
    chk("flush idle done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("flush no done", 32'(seen), 32'd0);
    chk("flush result kept", result, 32'h10);
    chk("flush carry kept", 32'(carry_out), 32'd0);

    // Back-to-back start in the DONE cycle.
    run_op(2'b00, 8'd4, 32'h1, 1'b0, cyc, nb, ok);
    chk("b2b first done", 32'(ok), 32'd1);
    shift_type = 2'b01; amount = 8'd1; operand = 32'h80000001; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand = 32'h0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b done low", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b result", result, 32'h40000000);
    chk("b2b carry", 32'(carry_out), 32'd1);

    // Flush in DONE suppresses the simultaneous start.
    shift_type = 2'b00; amount = 8'd0; operand = 32'h55AA55AA; carry_in = 1'b0;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("dflush busy", 32'(busy), 32'd0);
    chk("dflush done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("dflush done2", 32'(done), 32'd0);
    chk("dflush result", result, 32'h40000000);

    // Asynchronous reset mid-SHIFT.
    shift_type = 2'b00; amount = 8'd16; operand = 32'hFFFF; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst carry", 32'(carry_out), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst after busy", 32'(busy), 32'd0);
    chk("rst after done", 32'(done), 32'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      rt   = 2'($urandom_range(0, 3));
      ra   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      rop  = $urandom;
      rcin = 1'($urandom_range(0, 1));
      ref_shift(rt, int'(ra), rop, rcin, er, ec);
      op_check($sformatf("rand%0d t=%0d a=%0d", n, rt, ra), rt, ra, rop, rcin, er, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
